// File: rtl/sum_split_pkg.sv
// Shared definitions for the sum splitter.
//   state_e        : controller states (IDLE waits for a total, EMIT streams beats)
//   DEF_*          : default parameter values used by sum_splitter
package sum_split_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_CHUNK_MAX = 256;
  localparam int unsigned DEF_CNT_W     = 16;

endpackage

// File: rtl/sum_splitter.sv
// sum_splitter: accepts one total per transaction and emits it as a stream of
// beats, each no larger than the per-transaction limit, whose sum equals the
// total. One transaction in flight; one idle cycle between transactions.
//
// Ports:
//   clk, reset          clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   in_total            amount to split (sampled at accept only)
//   in_limit            max amount per beat; 0 selects CHUNK_MAX
//   out_valid/out_ready beat handshake
//   out_amt             amount of the current beat
//   out_last            current beat is the final one of the transaction
//   out_beat            0-based beat index, saturating
//   out_sum             sum of beats already accepted in this transaction
//   busy                transaction in progress
module sum_splitter
  import sum_split_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned CHUNK_MAX = DEF_CHUNK_MAX,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_total,
  input  logic [WIDTH-1:0] in_limit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_amt,
  output logic             out_last,
  output logic [CNT_W-1:0] out_beat,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy
);

  localparam logic [WIDTH-1:0] CHUNK_L = WIDTH'(CHUNK_MAX);

  state_e           state_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] lim_q;
  logic [WIDTH-1:0] amt_q;
  logic             last_q;
  logic [CNT_W-1:0] beat_q;
  logic [WIDTH-1:0] sum_q;

  logic [WIDTH-1:0] lim_sel;
  logic [WIDTH-1:0] rem_d;
  logic [WIDTH-1:0] lim_d;
  logic [WIDTH-1:0] amt_d;
  logic             last_d;

  // The beat presented after the next edge is computed from the remaining
  // amount that will hold after that edge: the fresh total on accept, or the
  // current remaining minus the beat being transferred. This keeps out_amt
  // and out_last registered without a path from out_ready.
  always_comb begin
    lim_sel = (in_limit == '0) ? CHUNK_L : in_limit;
    if (state_q == IDLE) begin
      rem_d = in_total;
      lim_d = lim_sel;
    end else begin
      rem_d = rem_q - amt_q;
      lim_d = lim_q;
    end
    last_d = (rem_d <= lim_d);
    amt_d  = last_d ? rem_d : lim_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      lim_q   <= '0;
      amt_q   <= '0;
      last_q  <= 1'b0;
      beat_q  <= '0;
      sum_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            rem_q   <= rem_d;
            lim_q   <= lim_d;
            amt_q   <= amt_d;
            last_q  <= last_d;
            beat_q  <= '0;
            sum_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            rem_q <= rem_d;
            sum_q <= sum_q + amt_q;
            if (beat_q != '1) begin
              beat_q <= beat_q + CNT_W'(1);
            end
            if (last_q) begin
              amt_q   <= '0;
              last_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              amt_q  <= amt_d;
              last_q <= last_d;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign out_amt   = amt_q;
  assign out_last  = last_q;
  assign out_beat  = beat_q;
  assign out_sum   = sum_q;

endmodule

// File: tb/tb_sum_splitter.sv
// Self-checking bench for sum_splitter: a reference model expands each
// accepted total into expected beats on a queue; beats are popped and
// compared as the DUT transfers them.
module tb_sum_splitter;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned CHUNK_MAX = 256;
  localparam int unsigned CNT_W     = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_total = '0;
  logic [WIDTH-1:0] in_limit = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_amt;
  logic             out_last;
  logic [CNT_W-1:0] out_beat;
  logic [WIDTH-1:0] out_sum;
  logic             busy;

  sum_splitter #(.WIDTH(WIDTH), .CHUNK_MAX(CHUNK_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_total(in_total), .in_limit(in_limit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_amt(out_amt), .out_last(out_last),
    .out_beat(out_beat), .out_sum(out_sum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint amt;
    bit     last;
    longint beat;
    longint sum;
    longint lim;
    longint total;
  } beat_t;

  beat_t  sbq[$];
  int     n_vec = 0;
  int     n_err = 0;
  longint acc = 0;
  bit     chk_idle = 1'b0;
  bit     rnd_mode = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_push(input longint total, input longint limit);
    longint lim, rem, k, s, a;
    beat_t  e;
    lim = (limit == 0) ? CHUNK_MAX : limit;
    rem = total;
    k = 0;
    s = 0;
    do begin
      a = (rem < lim) ? rem : lim;
      e.amt = a;
      e.last = (rem <= lim);
      e.beat = k;
      e.sum = s;
      e.lim = lim;
      e.total = total;
      sbq.push_back(e);
      s += a;
      rem -= a;
      k++;
    end while (!e.last);
  endtask

  // Monitor: samples on the falling edge, so a beat seen valid&&ready here
  // is the one transferred at the following rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      beat_t e;
      if (chk_idle) begin
        check("rdy_after_last", longint'(in_ready), 1);
        check("vld_after_last", longint'(out_valid), 0);
        chk_idle = 1'b0;
      end
      if (busy) check("rdy_while_busy", longint'(in_ready), 0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("amt", longint'(out_amt), e.amt);
          check("last", longint'(out_last), longint'(e.last));
          check("beat", longint'(out_beat), e.beat);
          check("sum", longint'(out_sum), e.sum);
          check("amt_le_lim", longint'(out_amt <= e.lim), 1);
          acc += longint'(out_amt);
          if (out_last) begin
            check("txn_total", acc, e.total);
            acc = 0;
            chk_idle = 1'b1;
          end
        end
      end
      if (in_valid && in_ready) model_push(longint'(in_total), longint'(in_limit));
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  task automatic send(input logic [WIDTH-1:0] total, input logic [WIDTH-1:0] limit);
    bit ok;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_total = total;
    in_limit = limit;
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Later changes must be ignored by the DUT.
    in_total = $urandom;
    in_limit = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (!busy && sbq.size() == 0) return;
    end
    check("idle_timeout", 1, 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", longint'(in_ready), 1);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_amt", longint'(out_amt), 0);
    check("rst_out_last", longint'(out_last), 0);
    check("rst_out_beat", longint'(out_beat), 0);
    check("rst_out_sum", longint'(out_sum), 0);
    check("rst_busy", longint'(busy), 0);
  endtask

  initial begin
    #100_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check_reset_outputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1000 split by 256
    out_ready = 1'b1;
    send(1000, 256);
    wait_idle();
    check("t1_sum_final", longint'(out_sum), 1000);
    check("t1_beats", longint'(out_beat), 4);
    check("t1_ready", longint'(in_ready), 1);

    // zero total: single zero beat
    send(0, 10);
    wait_idle();
    check("t2_beats", longint'(out_beat), 1);

    // exact multiple of CHUNK_MAX via in_limit=0
    send(512, 0);
    wait_idle();
    check("t3_sum_final", longint'(out_sum), 512);
    check("t3_beats", longint'(out_beat), 2);

    // stall after first beat
    out_ready = 1'b0;
    send(100, 30);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", longint'(out_valid), 1);
      check("stall_amt", longint'(out_amt), 30);
      check("stall_beat", longint'(out_beat), 1);
      check("stall_sum", longint'(out_sum), 30);
      check("stall_last", longint'(out_last), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_idle();
    check("t4_sum_final", longint'(out_sum), 100);

    // asynchronous reset mid-transaction
    send(1000, 100);
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    sbq.delete();
    acc = 0;
    chk_idle = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(5, 10);
    wait_idle();
    check("t5_sum_final", longint'(out_sum), 5);
    check("t5_beats", longint'(out_beat), 1);

    // random back-to-back totals with random backpressure
    rnd_mode = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [WIDTH-1:0] tot, lim;
      case ($urandom_range(0, 3))
        0: lim = '0;
        1: lim = WIDTH'($urandom_range(1, 9));
        default: lim = WIDTH'($urandom_range(10, 300));
      endcase
      if (lim != '0 && lim < 10) tot = WIDTH'($urandom_range(0, 50));
      else if ($urandom_range(0, 7) == 0) tot = '0;
      else tot = WIDTH'($urandom_range(1, 1500));
      send(tot, lim);
    end
    wait_idle();
    rnd_mode = 1'b0;
    check("queue_empty", longint'(sbq.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sum_splitter.md
Name: sum_splitter

Overview:
- Inverse of the team's running-sum accumulator: accepts one total per transaction and emits it as a stream of bounded amounts whose sum equals the total.
- Sits between a credit/total producer and any downstream consumer that takes at most a limited amount per beat.
- Valid/ready handshake on both sides; one transaction in flight at a time.

Parameters:
WIDTH, 32, data width of in_total, in_limit, out_amt, out_sum.
CHUNK_MAX, 256, per-beat limit used when in_limit == 0; must be >= 1 and < 2**WIDTH.
CNT_W, 16, width of out_beat counter (saturating).

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  total request present
in_ready  output  1  block can accept a request
in_total  input  WIDTH  amount to split
in_limit  input  WIDTH  max amount per beat; 0 selects CHUNK_MAX
out_valid  output  1  out_amt valid
out_ready  input  1  downstream accepts beat
out_amt  output  WIDTH  amount of current beat
out_last  output  1  current beat is final of transaction
out_beat  output  CNT_W  index of current beat, 0-based, saturates at all-ones
out_sum  output  WIDTH  sum of beats already accepted in current transaction
busy  output  1  transaction in progress (state != IDLE)

Behaviour:
- Reset (async, active-high): state=IDLE; in_ready=1; out_valid=0; out_amt=0; out_last=0; out_beat=0; out_sum=0; busy=0; internal remaining=0, limit=0. Reset mid-transaction drops it: no further beats.
- States: IDLE, EMIT.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready at edge N: latch remaining=in_total, lim=(in_limit==0 ? CHUNK_MAX : in_limit); out_beat=0; out_sum=0; go EMIT. out_valid high from cycle N+1 (latency 1).
- EMIT: in_ready=0; out_valid=1; out_amt=min(remaining, lim); out_last=(remaining <= lim).
- Beat handshake: beat transfers on out_valid&&out_ready at rising edge. On transfer: remaining -= out_amt; out_sum += out_amt; out_beat += 1 (saturating). If out_last: go IDLE; out_valid=0 and in_ready=1 next cycle. No same-cycle accept of a new request on the last beat (one idle cycle between transactions).
- Stall: while out_valid && !out_ready, out_amt, out_last, out_beat, out_sum are held stable.
- in_total==0: exactly one beat, out_amt=0, out_last=1.
- in_total an exact multiple of lim: final beat carries lim with out_last=1; never a trailing zero beat.
- Beat count per transaction = max(1, ceil(in_total/lim)).
- in_total, in_limit sampled only at accept; later changes ignored.
- Invariant: out_sum + remaining == latched total at all times in EMIT. The arithmetic cannot overflow, so no wrap handling is required.
- out_amt, out_last, out_valid are registered outputs (no combinational path from out_ready or in_valid). in_ready derives from state only.

Decomposition:
- Package sum_split_pkg: state enum typedef (IDLE, EMIT), default WIDTH/CHUNK_MAX localparams.
- Flat module; the min/last computation is a small combinational block inside it, no sub-module required.

Test Plan:
- in_total=1000, in_limit=256, out_ready=1 -> beats 256,256,256,232; out_last only on 4th; out_beat 0..3; out_sum=1000 after last; in_ready back high 1 cycle after last.
- in_total=0, in_limit=10 -> single beat out_amt=0, out_last=1, then IDLE.
- in_total=512, in_limit=0 (CHUNK_MAX=256) -> beats 256,256; last on 2nd; no zero beat.
- in_total=100, in_limit=30, out_ready low for 3 cycles after beat 1 -> out_amt=30, out_beat=1, out_sum=30 held steady while stalled; beats 30,30,30,10 overall.
- Reset asserted asynchronously mid-way through in_total=1000, in_limit=100 -> all outputs at reset values immediately; after release, new in_total=5 gives a single beat of 5 with out_last=1.
- Random back-to-back totals and limits with random out_ready, checked by an accumulator scoreboard -> per-transaction beat sum equals in_total; each beat <= limit; in_ready=0 whenever busy=1.
